// File: rtl/pkt_buf_slot_mgr_pkg.sv
// ============================================================================
// Module  : pkt_buf_slot_mgr_pkg
// Brief   : Shared constants, state encoding and helpers for the slot manager.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pkt_buf_slot_mgr_pkg;

    localparam int SLOT_BITS   = 4;
    localparam int OFFSET_BITS = 7;
    localparam int ADDR_BITS   = SLOT_BITS + OFFSET_BITS;
    localparam int NUM_SLOTS   = 1 << SLOT_BITS;
    localparam int META_W      = 340;
    localparam int DATA_W      = 139;
    localparam logic [2:0] TAIL_CODE = 3'b110;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        IDLE       = 3'd1,
        WAIT_SPACE = 3'd2,
        READ       = 3'd3,
        RELEASE    = 3'd4
    } state_t;

    function automatic logic is_tail(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: 3] == TAIL_CODE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_buf_slot_mgr_if.sv
// ============================================================================
// Module  : pkt_buf_slot_mgr_if
// Brief   : Slot-free, descriptor, packet RAM and packet output signal bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pkt_buf_slot_mgr_if;
    import pkt_buf_slot_mgr_pkg::*;

    logic                   slot_free_wr;
    logic [SLOT_BITS-1:0]   slot_free_id;
    logic                   meta_in_valid;
    logic [META_W-1:0]      meta_in;
    logic                   ram_rd;
    logic [ADDR_BITS-1:0]   ram_rd_addr;
    logic [DATA_W-1:0]      ram_q;
    logic [7:0]             pkt_out_usedw;
    logic                   pkt_out_valid;
    logic [DATA_W-1:0]      pkt_out_data;
    logic                   meta_out_valid;
    logic [META_W-1:0]      meta_out;

    modport master (
        output slot_free_wr, slot_free_id, ram_rd, ram_rd_addr,
               pkt_out_valid, pkt_out_data, meta_out_valid, meta_out,
        input  meta_in_valid, meta_in, ram_q, pkt_out_usedw
    );

    modport slave (
        input  slot_free_wr, slot_free_id, ram_rd, ram_rd_addr,
               pkt_out_valid, pkt_out_data, meta_out_valid, meta_out,
        output meta_in_valid, meta_in, ram_q, pkt_out_usedw
    );

endinterface

`default_nettype wire

// File: rtl/pkt_desc_fifo.sv
// ============================================================================
// Module  : pkt_desc_fifo
// Brief   : Descriptor queue with registered read data and full/empty flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_desc_fifo
    import pkt_buf_slot_mgr_pkg::*;
#(
    parameter int DEPTH = NUM_SLOTS,
    parameter int WIDTH = META_W
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_wr_en,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic             i_rd_en,
    output logic      [WIDTH-1:0] o_q,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Fullness is judged before any same-cycle pop, so a full queue drops the write.
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_wr_en && !o_full;
    assign w_pop   = i_rd_en && !o_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            o_q      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                o_q      <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pkt_buf_slot_mgr.sv
// ============================================================================
// Module  : pkt_buf_slot_mgr
// Brief   : Seeds free slots, reads queued packets out of slot RAM, recycles slots.
//           Optional statistics counters: define PKT_BUF_SLOT_MGR_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_buf_slot_mgr
    import pkt_buf_slot_mgr_pkg::*;
#(
    parameter logic [7:0] USEDW_MAX  = 8'd127,
    parameter int         SLOT_WORDS = 128
) (
    input  wire logic           clk,
    input  wire logic           reset,
    pkt_buf_slot_mgr_if.master  bus,
    output logic                err_ovf,
    output logic [31:0]         stat_pkt_cnt,
    output logic [15:0]         stat_trunc_cnt
);

    localparam logic [OFFSET_BITS-1:0] c_last_off = OFFSET_BITS'(SLOT_WORDS - 1);

    state_t                 r_state, w_state_nxt;
    logic [SLOT_BITS-1:0]   r_init_id, w_init_id_nxt;
    logic                   r_free_wr, w_free_wr_nxt;
    logic [SLOT_BITS-1:0]   r_free_id, w_free_id_nxt;
    logic                   r_ram_rd, w_ram_rd_nxt;
    logic [OFFSET_BITS-1:0] r_rd_off, w_rd_off_nxt;
    logic                   r_rd_pend;
    logic [OFFSET_BITS-1:0] r_q_off;
    logic                   r_first, w_first_nxt;
    logic                   r_tail_seen, w_tail_seen_nxt;
    logic                   r_err_ovf;
    logic                   w_pop;

    logic [META_W-1:0]      w_desc;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [SLOT_BITS-1:0]   w_slot;

    logic                   w_word_valid;
    logic                   w_word_tail;
    logic                   w_word_last;
    logic                   w_end;
    logic                   w_trunc;
    logic [DATA_W-1:0]      w_word;

    pkt_desc_fifo #(
        .DEPTH (NUM_SLOTS),
        .WIDTH (META_W)
    ) u_desc_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (bus.meta_in_valid),
        .i_wr_data (bus.meta_in),
        .i_rd_en   (w_pop),
        .o_q       (w_desc),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // The popped descriptor stays on the queue output until the next pop in IDLE.
    assign w_slot = w_desc[META_W-1 -: SLOT_BITS];

    // Word on ram_q this cycle; anything read after the tail is discarded.
    always_comb begin
        w_word_valid = r_rd_pend && !r_tail_seen;
        w_word_tail  = is_tail(bus.ram_q);
        w_word_last  = (r_q_off == c_last_off);
        w_end        = w_word_valid && (w_word_tail || w_word_last);
        w_trunc      = w_word_valid && w_word_last && !w_word_tail;
        w_word       = bus.ram_q;
        if (w_trunc) begin
            w_word[DATA_W-1 -: 3] = TAIL_CODE;
        end
    end

    assign bus.pkt_out_valid  = w_word_valid;
    assign bus.pkt_out_data   = w_word_valid ? w_word : '0;
    assign bus.meta_out_valid = w_word_valid && r_first;
    assign bus.meta_out       = (w_word_valid && r_first) ? w_desc : '0;
    assign bus.ram_rd         = r_ram_rd;
    assign bus.ram_rd_addr    = {w_slot, r_rd_off};
    assign bus.slot_free_wr   = r_free_wr;
    assign bus.slot_free_id   = r_free_id;
    assign err_ovf            = r_err_ovf;

    always_comb begin
        w_state_nxt     = r_state;
        w_init_id_nxt   = r_init_id;
        w_free_wr_nxt   = 1'b0;
        w_free_id_nxt   = r_free_id;
        w_ram_rd_nxt    = 1'b0;
        w_rd_off_nxt    = r_rd_off;
        w_first_nxt     = r_first && !w_word_valid;
        w_tail_seen_nxt = r_tail_seen || w_end;
        w_pop           = 1'b0;
        unique case (r_state)
            INIT: begin
                w_free_wr_nxt = 1'b1;
                w_free_id_nxt = r_init_id;
                w_init_id_nxt = r_init_id + SLOT_BITS'(1);
                if (r_init_id == '1) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (bus.pkt_out_usedw <= USEDW_MAX) begin
                    w_ram_rd_nxt    = 1'b1;
                    w_rd_off_nxt    = '0;
                    w_first_nxt     = 1'b1;
                    w_tail_seen_nxt = 1'b0;
                    w_state_nxt     = READ;
                end
            end
            READ: begin
                // Stop issuing at the last slot word so the offset never wraps.
                if (w_end) begin
                    w_state_nxt = RELEASE;
                end else if (r_ram_rd && (r_rd_off != c_last_off)) begin
                    w_ram_rd_nxt = 1'b1;
                    w_rd_off_nxt = r_rd_off + OFFSET_BITS'(1);
                end
            end
            RELEASE: begin
                w_free_wr_nxt = 1'b1;
                w_free_id_nxt = w_slot;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= INIT;
            r_init_id   <= '0;
            r_free_wr   <= 1'b0;
            r_free_id   <= '0;
            r_ram_rd    <= 1'b0;
            r_rd_off    <= '0;
            r_rd_pend   <= 1'b0;
            r_q_off     <= '0;
            r_first     <= 1'b0;
            r_tail_seen <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_id   <= w_init_id_nxt;
            r_free_wr   <= w_free_wr_nxt;
            r_free_id   <= w_free_id_nxt;
            r_ram_rd    <= w_ram_rd_nxt;
            r_rd_off    <= w_rd_off_nxt;
            r_rd_pend   <= r_ram_rd;
            r_q_off     <= r_rd_off;
            r_first     <= w_first_nxt;
            r_tail_seen <= w_tail_seen_nxt;
            r_err_ovf   <= r_err_ovf || (bus.meta_in_valid && w_fifo_full);
        end
    end

`ifdef PKT_BUF_SLOT_MGR_STATS_EN
    logic        w_pkt_done;
    logic [31:0] r_pkt_cnt;
    logic [15:0] r_trunc_cnt;

    assign w_pkt_done = (r_state == RELEASE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pkt_cnt   <= '0;
            r_trunc_cnt <= '0;
        end else begin
            if (w_pkt_done && (r_pkt_cnt != '1)) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_trunc && (r_trunc_cnt != '1)) begin
                r_trunc_cnt <= r_trunc_cnt + 16'd1;
            end
        end
    end

    assign stat_pkt_cnt   = r_pkt_cnt;
    assign stat_trunc_cnt = r_trunc_cnt;
`else
    assign stat_pkt_cnt   = '0;
    assign stat_trunc_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pkt_buf_slot_mgr.sv
// ============================================================================
// Module  : tb_pkt_buf_slot_mgr
// Brief   : Directed bench for the slot manager with a 1-cycle packet RAM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_buf_slot_mgr;

`ifdef PKT_BUF_SLOT_MGR_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        err_ovf;
    logic [31:0] stat_pkt_cnt;
    logic [15:0] stat_trunc_cnt;
    int          total = 0;
    int          bad   = 0;

    pkt_buf_slot_mgr_if bus ();

    pkt_buf_slot_mgr #(
        .USEDW_MAX  (8'd127),
        .SLOT_WORDS (128)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .err_ovf        (err_ovf),
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_trunc_cnt (stat_trunc_cnt)
    );

    always #5 clk = ~clk;

    // Packet RAM: data appears one cycle after the read strobe.
    logic [138:0] mem [2048];
    always @(posedge clk) begin
        if (bus.ram_rd) bus.ram_q <= mem[bus.ram_rd_addr];
    end

    logic [10:0]  rd_q[$];
    logic [138:0] word_q[$];
    logic         meta_flag_q[$];
    logic [339:0] meta_q[$];
    logic [3:0]   free_q[$];

    always @(negedge clk) begin
        if (reset) begin
            if (bus.ram_rd)         rd_q.push_back(bus.ram_rd_addr);
            if (bus.pkt_out_valid) begin
                word_q.push_back(bus.pkt_out_data);
                meta_flag_q.push_back(bus.meta_out_valid);
            end
            if (bus.meta_out_valid) meta_q.push_back(bus.meta_out);
            if (bus.slot_free_wr)   free_q.push_back(bus.slot_free_id);
        end
    end

    task automatic chk(input string tag, input logic [339:0] obs, input logic [339:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [339:0] d);
        bus.meta_in       = d;
        bus.meta_in_valid = 1'b1;
        step(1);
        bus.meta_in_valid = 1'b0;
    endtask

    task automatic wait_free(input string tag, input int n, input int lim);
        int t = 0;
        while (free_q.size() < n && t < lim) begin
            step(1);
            t++;
        end
        chk(tag, free_q.size() >= n, 1'b1);
    endtask

    initial begin
        int rb, wb, mb, fb;
        logic [339:0] d;
        logic [339:0] e;

        for (int a = 0; a < 2048; a++) mem[a] = {3'b000, 136'(a) ^ 136'h5A5A0000};
        mem[11'h283][138:136] = 3'b110;
        mem[11'h181][138:136] = 3'b110;
        bus.meta_in_valid = 1'b0;
        bus.meta_in       = '0;
        bus.pkt_out_usedw = 8'd0;

        // Reset state
        step(3);
        chk("rst_free_wr", bus.slot_free_wr, 1'b0);
        chk("rst_ram_rd", bus.ram_rd, 1'b0);
        chk("rst_pkt_valid", bus.pkt_out_valid, 1'b0);
        chk("rst_meta_valid", bus.meta_out_valid, 1'b0);
        chk("rst_err_ovf", err_ovf, 1'b0);
        chk("rst_stat_pkt", stat_pkt_cnt, 32'd0);

        // Slot seeding after reset release
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk("init_wr", bus.slot_free_wr, 1'b1);
            chk("init_id", bus.slot_free_id, i);
        end
        step(1);
        chk("init_end", bus.slot_free_wr, 1'b0);

        // Slot 5, 4-word packet, tail at word 3
        rb = rd_q.size(); wb = word_q.size(); mb = meta_q.size(); fb = free_q.size();
        d = {4'd5, 336'hC0FFEE0041};
        send(d);
        wait_free("t41_timeout", fb + 1, 100);
        step(3);
        chk("t41_nrd", rd_q.size() - rb, 5);
        for (int k = 0; k < 4; k++) chk("t41_addr", rd_q[rb + k], 11'h280 + k);
        chk("t41_nwords", word_q.size() - wb, 4);
        chk("t41_w0", word_q[wb], mem[11'h280]);
        chk("t41_w3", word_q[wb + 3], mem[11'h283]);
        chk("t41_meta_n", meta_q.size() - mb, 1);
        chk("t41_meta", meta_q[mb], d);
        chk("t41_meta_first", meta_flag_q[wb], 1'b1);
        chk("t41_free", free_q[fb], 4'd5);

        // Output back-pressure, including the level just above the threshold
        bus.pkt_out_usedw = 8'd200;
        rb = rd_q.size(); wb = word_q.size(); fb = free_q.size();
        send({4'd3, 336'h42});
        step(10);
        chk("t42_stall200", rd_q.size() - rb, 0);
        bus.pkt_out_usedw = 8'd128;
        step(5);
        chk("t42_stall128", rd_q.size() - rb, 0);
        bus.pkt_out_usedw = 8'd100;
        step(1);
        chk("t42_rd_start", bus.ram_rd, 1'b1);
        chk("t42_addr0", bus.ram_rd_addr, 11'h180);
        wait_free("t42_timeout", fb + 1, 100);
        step(3);
        chk("t42_nwords", word_q.size() - wb, 2);
        chk("t42_free", free_q[fb], 4'd3);

        // Slot 2 without a tail: truncated at 128 words, threshold level 127
        bus.pkt_out_usedw = 8'd127;
        rb = rd_q.size(); wb = word_q.size(); fb = free_q.size();
        send({4'd2, 336'h43});
        wait_free("t43_timeout", fb + 1, 400);
        step(3);
        chk("t43_nrd", rd_q.size() - rb, 128);
        chk("t43_last_addr", rd_q[rb + 127], 11'h17F);
        chk("t43_nwords", word_q.size() - wb, 128);
        chk("t43_w126", word_q[wb + 126], mem[11'h17E]);
        e = '0;
        e[138:0] = {3'b110, mem[11'h17F][135:0]};
        chk("t43_w127_forced", word_q[wb + 127], e);
        chk("t43_trunc_cnt", stat_trunc_cnt, 16'(STATS));
        chk("t43_pkt_cnt", stat_pkt_cnt, 32'(3 * STATS));
        chk("t43_free", free_q[fb], 4'd2);

        // Reset in the middle of a read with one descriptor still queued
        bus.pkt_out_usedw = 8'd0;
        rb = rd_q.size();
        send({4'd2, 336'h45});
        for (int t = 0; t < 100 && rd_q.size() < rb + 20; t++) step(1);
        chk("t45_reading", rd_q.size() >= rb + 20, 1'b1);
        send({4'd5, 336'h46});
        #2 reset = 1'b0;
        #1;
        chk("t45_ram_rd", bus.ram_rd, 1'b0);
        chk("t45_addr", bus.ram_rd_addr, 11'h000);
        chk("t45_pkt_valid", bus.pkt_out_valid, 1'b0);
        chk("t45_pkt_data", bus.pkt_out_data, 139'd0);
        chk("t45_meta_valid", bus.meta_out_valid, 1'b0);
        chk("t45_free_wr", bus.slot_free_wr, 1'b0);
        chk("t45_trunc_cnt", stat_trunc_cnt, 16'd0);
        step(2);
        fb = free_q.size(); rb = rd_q.size(); wb = word_q.size();
        reset = 1'b1;
        step(20);
        chk("t45_nfree", free_q.size() - fb, 16);
        chk("t45_free0", free_q[fb], 4'd0);
        chk("t45_free15", free_q[fb + 15], 4'd15);
        step(30);
        chk("t45_no_rd", rd_q.size() - rb, 0);
        chk("t45_no_words", word_q.size() - wb, 0);

        // 17 descriptors during seeding with the output stalled
        reset = 1'b0;
        step(2);
        bus.pkt_out_usedw = 8'd200;
        fb = free_q.size(); mb = meta_q.size(); wb = word_q.size();
        reset = 1'b1;
        bus.meta_in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            bus.meta_in = {4'd3, 336'(k)};
            step(1);
            if (k == 15) chk("t44_ovf_before", err_ovf, 1'b0);
        end
        bus.meta_in_valid = 1'b0;
        chk("t44_ovf", err_ovf, 1'b1);
        step(5);
        bus.pkt_out_usedw = 8'd0;
        wait_free("t44_timeout", fb + 32, 600);
        step(40);
        chk("t44_nfree", free_q.size() - fb, 32);
        chk("t44_npkts", meta_q.size() - mb, 16);
        chk("t44_nwords", word_q.size() - wb, 32);
        d = meta_q[mb];
        chk("t44_first_desc", d[335:0], 336'd0);
        d = meta_q[mb + 15];
        chk("t44_last_desc", d[335:0], 336'd15);
        chk("t44_pkt_cnt", stat_pkt_cnt, 32'(16 * STATS));
        chk("t44_ovf_sticky", err_ovf, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
